dram_pair_scheduler: RTL and testbench
======================================

Name: dram_pair_scheduler

Overview:
- Shares the single AFU DRAM read-request port between N_REQ requesters, e.g. hand-shake polling, read loading and BWT occurrence lookup.
- Each requester asks for an address pair (k, l). The block grants one requester round-robin and issues k then l on consecutive cycles.
- It enforces an outstanding-pair credit limit, re-pairs the in-order responses using the odd/even beat order, and returns each pair tagged with the requester ID.
- Sits between the request/response FIFOs and the 400 MHz TX_RD/RX_RD interface.

Parameters:
N_REQ, 3, number of requesters (2..8)
ID_W, 2, requester ID width, at least clog2(N_REQ)
MAX_OUT, 8, maximum outstanding pairs (power of two, 2..32)
ADDR_W, 58, cache-line address width

Ports:
CLK_400M  in  1  clock
spl_reset  in  1  asynchronous active-high reset
clear  in  1  synchronous flush, same effect as reset
req_valid  in  N_REQ  per-requester pair request
req_addr_k  in  N_REQ*ADDR_W  packed k addresses, requester i at [i*ADDR_W +: ADDR_W]
req_addr_l  in  N_REQ*ADDR_W  packed l addresses
req_ready  out  N_REQ  one-hot grant pulse
spl_tx_rd_almostfull  in  1  TX_RD back-pressure
cor_tx_rd_valid  out  1  read request valid
cor_tx_rd_addr  out  ADDR_W  read request address
io_rx_rd_valid  in  1  response beat valid
io_rx_data  in  512  response beat
rsp_valid  out  1  paired response valid, one-cycle pulse
rsp_id  out  ID_W  requester that owns the pair
rsp_data_k  out  512  k cache line
rsp_data_l  out  512  l cache line
outstanding  out  clog2(MAX_OUT)+1  pairs in flight
err_unexpected  out  1  sticky: response beat arrived with no pair in flight

Behaviour:
- Reset or clear: all outputs 0. FSM goes to ARB, round-robin pointer to 0, rx_phase to 0, tag FIFO emptied, err_unexpected cleared.
- States: ARB, ISSUE_L.
- ARB grant conditions, all required: any req_valid, spl_tx_rd_almostfull = 0, outstanding < MAX_OUT, tag FIFO not full.
- ARB grant actions, in the same cycle:
  - Winner = first valid requester at or after the pointer, wrapping.
  - req_ready[winner] = 1.
  - Register cor_tx_rd_valid = 1 and cor_tx_rd_addr = addr_k, visible next cycle.
  - Latch addr_l, push winner ID into the tag FIFO, increment outstanding.
  - Pointer becomes winner + 1 mod N_REQ.
  - Go to ISSUE_L.
- ISSUE_L: registers cor_tx_rd_valid = 1 and addr_l unconditionally (almostfull slack covers it), then returns to ARB. Pairs are never split.
- Maximum throughput is one pair per two cycles. The request address must be held until req_ready.
- Response path (responses return in request order):
  - rx_phase 0: beat stored in k_hold, rx_phase goes to 1.
  - rx_phase 1: next cycle rsp_valid = 1, rsp_data_k = k_hold, rsp_data_l = beat, rsp_id = tag FIFO head (popped); outstanding decrements; rx_phase goes to 0.
- Response latency: rsp_valid one cycle after the l beat.
- rsp has no back-pressure.
- Simultaneous increment and decrement leave outstanding unchanged.
- Beat with rx_phase 0 and tag FIFO empty: set err_unexpected; the beat is still captured, and outstanding never underflows (saturates at 0).
- Clear mid-pair drops any in-flight beats and tags.

Optional Feature:
- Macro DRAM_PAIR_PERF_CNT_EN.
- When defined, adds output perf_grant_cnt (32, N_REQ×32 packed) per requester and perf_stall_cyc (32).
  - perf_grant_cnt increments on each grant.
  - perf_stall_cyc counts ARB cycles with any req_valid but no grant.
  - All counters clear on reset or clear and wrap at 2^32.
- Undefined: these ports and logic are absent.

Decomposition:
- Package dram_pair_pkg: ADDR_W default, FSM state encoding (ARB, ISSUE_L), and the clog2 helper function.
- One sub-module, dram_pair_tag_fifo: synchronous FIFO of ID_W bits, depth MAX_OUT, with push/pop/full/empty and a clear input.

Test Plan:
- Single request, requester 1, k=0x100, l=0x2A0: tx valid at cycles t+1 and t+2 with 0x100 then 0x2A0. Return beats A then B: rsp_valid with id=1, k=A, l=B; outstanding goes 1 then 0.
- All three requesters held valid for 6 grants: grant order 0,1,2,0,1,2 and tx addresses alternate k/l per pair.
- MAX_OUT=8 with no responses: after 8 grants req_ready stays 0. One returned pair releases exactly one more grant.
- spl_tx_rd_almostfull asserted during ISSUE_L: l still issued; ARB then holds until almostfull drops.
- Beat with no pair in flight: err_unexpected=1, outstanding stays 0. Clear returns everything to reset values.
- With DRAM_PAIR_PERF_CNT_EN: 5 grants to requester 2 give perf_grant_cnt[2]=5; 4 almostfull-blocked cycles give perf_stall_cyc=4.

Source files
------------

// File: rtl/dram_pair_pkg.sv
// Shared types and helpers for the DRAM pair scheduler: default address width,
// arbiter FSM encoding and a constant-foldable ceil(log2) helper.
package dram_pair_pkg;

  localparam int ADDR_W_DEF = 58;

  typedef enum logic [0:0] {
    ARB     = 1'b0,
    ISSUE_L = 1'b1
  } dp_state_e;

  function automatic int dp_clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      result = ((32'd1 << i) < value) ? (i + 1) : result;
    end
    return result;
  endfunction

endpackage

// File: rtl/dram_pair_scheduler_if.sv
// Request, TX_RD, RX_RD and paired-response signals of the DRAM pair scheduler.
// The scheduler takes the slave modport; the requester/AFU side takes master.
interface dram_pair_scheduler_if
  import dram_pair_pkg::*;
#(
  parameter int N_REQ  = 3,
  parameter int ID_W   = 2,
  parameter int ADDR_W = ADDR_W_DEF
);

  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*ADDR_W-1:0] req_addr_k;
  logic [N_REQ*ADDR_W-1:0] req_addr_l;
  logic [N_REQ-1:0]        req_ready;
  logic                    spl_tx_rd_almostfull;
  logic                    cor_tx_rd_valid;
  logic [ADDR_W-1:0]       cor_tx_rd_addr;
  logic                    io_rx_rd_valid;
  logic [511:0]            io_rx_data;
  logic                    rsp_valid;
  logic [ID_W-1:0]         rsp_id;
  logic [511:0]            rsp_data_k;
  logic [511:0]            rsp_data_l;

  modport master (
    output req_valid, req_addr_k, req_addr_l, spl_tx_rd_almostfull,
    output io_rx_rd_valid, io_rx_data,
    input  req_ready, cor_tx_rd_valid, cor_tx_rd_addr,
    input  rsp_valid, rsp_id, rsp_data_k, rsp_data_l
  );

  modport slave (
    input  req_valid, req_addr_k, req_addr_l, spl_tx_rd_almostfull,
    input  io_rx_rd_valid, io_rx_data,
    output req_ready, cor_tx_rd_valid, cor_tx_rd_addr,
    output rsp_valid, rsp_id, rsp_data_k, rsp_data_l
  );

endinterface

// File: rtl/dram_pair_tag_fifo.sv
// Synchronous FIFO holding requester IDs of pairs in flight, in issue order.
// Push on full and pop on empty are ignored.
module dram_pair_tag_fifo
  import dram_pair_pkg::*;
#(
  parameter  int WIDTH = 2,
  parameter  int DEPTH = 8,
  localparam int PTR_W = dp_clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign full      = (count_r == CNT_W'(DEPTH));
  assign empty     = (count_r == {CNT_W{1'b0}});
  assign head      = mem_r[rd_ptr_r];
  assign do_push_s = push & ~full;
  assign do_pop_s  = pop & ~empty;

  // Storage array; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (clear) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      case ({do_push_s, do_pop_s})
        2'b10:   count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        2'b01:   count_r <= count_r - {{(CNT_W-1){1'b0}}, 1'b1};
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/dram_pair_scheduler.sv
// Round-robin scheduler issuing (k, l) read pairs onto one DRAM read port and
// re-pairing in-order responses. Optional counters: define DRAM_PAIR_PERF_CNT_EN.
module dram_pair_scheduler
  import dram_pair_pkg::*;
#(
  parameter  int N_REQ   = 3,
  parameter  int ID_W    = 2,
  parameter  int MAX_OUT = 8,
  parameter  int ADDR_W  = ADDR_W_DEF,
  localparam int OUT_W   = dp_clog2(MAX_OUT) + 1
) (
  input  logic                  CLK_400M,
  input  logic                  spl_reset,
  input  logic                  clear,
  dram_pair_scheduler_if.slave  bus,
  output logic [OUT_W-1:0]      outstanding,
  output logic                  err_unexpected
`ifdef DRAM_PAIR_PERF_CNT_EN
  ,
  output logic [N_REQ*32-1:0]   perf_grant_cnt,
  output logic [31:0]           perf_stall_cyc
`endif
);

  dp_state_e         state_r;
  dp_state_e         state_nxt_s;
  logic [ID_W-1:0]   ptr_r;
  logic [ID_W-1:0]   winner_s;
  logic [ADDR_W-1:0] addr_k_s;
  logic [ADDR_W-1:0] addr_l_s;
  logic [ADDR_W-1:0] addr_l_r;
  logic [N_REQ-1:0]  ready_s;
  logic              grant_s;
  logic              tx_valid_r;
  logic [ADDR_W-1:0] tx_addr_r;
  logic              rx_phase_r;
  logic [511:0]      k_hold_r;
  logic              rsp_valid_r;
  logic [ID_W-1:0]   rsp_id_r;
  logic [511:0]      rsp_k_r;
  logic [511:0]      rsp_l_r;
  logic              pair_done_s;
  logic              dec_s;
  logic              tag_full_s;
  logic              tag_empty_s;
  logic [ID_W-1:0]   tag_head_s;

  assign bus.req_ready       = ready_s;
  assign bus.cor_tx_rd_valid = tx_valid_r;
  assign bus.cor_tx_rd_addr  = tx_addr_r;
  assign bus.rsp_valid       = rsp_valid_r;
  assign bus.rsp_id          = rsp_id_r;
  assign bus.rsp_data_k      = rsp_k_r;
  assign bus.rsp_data_l      = rsp_l_r;

  assign pair_done_s = bus.io_rx_rd_valid & rx_phase_r;
  assign dec_s       = pair_done_s & (outstanding != {OUT_W{1'b0}});

  // Round-robin winner: lowest valid index at/after ptr beats any wrapped index
  always_comb begin
    winner_s = {ID_W{1'b0}};
    addr_k_s = {ADDR_W{1'b0}};
    addr_l_s = {ADDR_W{1'b0}};
    for (int j = N_REQ - 1; j >= 0; j--) begin
      winner_s = (bus.req_valid[j] && (ID_W'(j) < ptr_r)) ? ID_W'(j) : winner_s;
    end
    for (int j = N_REQ - 1; j >= 0; j--) begin
      winner_s = (bus.req_valid[j] && (ID_W'(j) >= ptr_r)) ? ID_W'(j) : winner_s;
    end
    for (int j = 0; j < N_REQ; j++) begin
      addr_k_s = (winner_s == ID_W'(j)) ? bus.req_addr_k[j*ADDR_W +: ADDR_W] : addr_k_s;
      addr_l_s = (winner_s == ID_W'(j)) ? bus.req_addr_l[j*ADDR_W +: ADDR_W] : addr_l_s;
    end
  end

  // FSM next state and grant decision
  always_comb begin
    state_nxt_s = state_r;
    grant_s     = 1'b0;
    ready_s     = {N_REQ{1'b0}};
    case (state_r)
      ARB: begin
        if ((|bus.req_valid) && !bus.spl_tx_rd_almostfull &&
            (outstanding < OUT_W'(MAX_OUT)) && !tag_full_s && !clear) begin
          grant_s     = 1'b1;
          ready_s     = {{(N_REQ-1){1'b0}}, 1'b1} << winner_s;
          state_nxt_s = ISSUE_L;
        end else begin
          state_nxt_s = ARB;
        end
      end
      ISSUE_L: state_nxt_s = ARB;
      default: state_nxt_s = ARB;
    endcase
  end

  // Request side: FSM state, round-robin pointer, k then l on TX_RD
  always_ff @(posedge CLK_400M or posedge spl_reset) begin
    if (spl_reset) begin
      state_r    <= ARB;
      ptr_r      <= {ID_W{1'b0}};
      addr_l_r   <= {ADDR_W{1'b0}};
      tx_valid_r <= 1'b0;
      tx_addr_r  <= {ADDR_W{1'b0}};
    end else if (clear) begin
      state_r    <= ARB;
      ptr_r      <= {ID_W{1'b0}};
      addr_l_r   <= {ADDR_W{1'b0}};
      tx_valid_r <= 1'b0;
      tx_addr_r  <= {ADDR_W{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      tx_valid_r <= 1'b0;
      if (grant_s) begin
        ptr_r      <= (winner_s == ID_W'(N_REQ - 1)) ? {ID_W{1'b0}}
                                                     : winner_s + {{(ID_W-1){1'b0}}, 1'b1};
        addr_l_r   <= addr_l_s;
        tx_valid_r <= 1'b1;
        tx_addr_r  <= addr_k_s;
      end else if (state_r == ISSUE_L) begin
        // l goes out regardless of almostfull; the FIFO slack absorbs it
        tx_valid_r <= 1'b1;
        tx_addr_r  <= addr_l_r;
      end
    end
  end

  // Response side: pair beats by phase, tag with FIFO head, track credits
  always_ff @(posedge CLK_400M or posedge spl_reset) begin
    if (spl_reset) begin
      rx_phase_r     <= 1'b0;
      k_hold_r       <= 512'd0;
      rsp_valid_r    <= 1'b0;
      rsp_id_r       <= {ID_W{1'b0}};
      rsp_k_r        <= 512'd0;
      rsp_l_r        <= 512'd0;
      outstanding    <= {OUT_W{1'b0}};
      err_unexpected <= 1'b0;
    end else if (clear) begin
      rx_phase_r     <= 1'b0;
      k_hold_r       <= 512'd0;
      rsp_valid_r    <= 1'b0;
      rsp_id_r       <= {ID_W{1'b0}};
      rsp_k_r        <= 512'd0;
      rsp_l_r        <= 512'd0;
      outstanding    <= {OUT_W{1'b0}};
      err_unexpected <= 1'b0;
    end else begin
      rsp_valid_r <= 1'b0;
      if (bus.io_rx_rd_valid && !rx_phase_r) begin
        k_hold_r   <= bus.io_rx_data;
        rx_phase_r <= 1'b1;
        if (tag_empty_s) err_unexpected <= 1'b1;
      end else if (pair_done_s) begin
        rsp_valid_r <= 1'b1;
        rsp_id_r    <= tag_head_s;
        rsp_k_r     <= k_hold_r;
        rsp_l_r     <= bus.io_rx_data;
        rx_phase_r  <= 1'b0;
      end
      case ({grant_s, dec_s})
        2'b10:   outstanding <= outstanding + {{(OUT_W-1){1'b0}}, 1'b1};
        2'b01:   outstanding <= outstanding - {{(OUT_W-1){1'b0}}, 1'b1};
        default: outstanding <= outstanding;
      endcase
    end
  end

  dram_pair_tag_fifo #(
    .WIDTH (ID_W),
    .DEPTH (MAX_OUT)
  ) u_tag_fifo (
    .clk       (CLK_400M),
    .rst       (spl_reset),
    .clear     (clear),
    .push      (grant_s),
    .push_data (winner_s),
    .pop       (pair_done_s),
    .head      (tag_head_s),
    .full      (tag_full_s),
    .empty     (tag_empty_s)
  );

`ifdef DRAM_PAIR_PERF_CNT_EN
  // Per-requester grant counts and blocked-arbitration cycle count, wrapping
  always_ff @(posedge CLK_400M or posedge spl_reset) begin
    if (spl_reset) begin
      perf_grant_cnt <= {(N_REQ*32){1'b0}};
      perf_stall_cyc <= 32'd0;
    end else if (clear) begin
      perf_grant_cnt <= {(N_REQ*32){1'b0}};
      perf_stall_cyc <= 32'd0;
    end else begin
      for (int j = 0; j < N_REQ; j++) begin
        if (grant_s && (winner_s == ID_W'(j))) begin
          perf_grant_cnt[j*32 +: 32] <= perf_grant_cnt[j*32 +: 32] + 32'd1;
        end
      end
      if ((state_r == ARB) && (|bus.req_valid) && !grant_s) begin
        perf_stall_cyc <= perf_stall_cyc + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dram_pair_scheduler.sv
// Directed self-checking bench for dram_pair_scheduler (N_REQ=3, MAX_OUT=8).
// Inputs change and outputs are sampled 1-2 ns after each rising edge.
module tb_dram_pair_scheduler;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [3:0]  outstanding;
  logic        err;
  int          checks;
  int          failures;
  logic [57:0] k_tab [3];
  logic [57:0] l_tab [3];
  logic [511:0] beat_a;
  logic [511:0] beat_b;
`ifdef DRAM_PAIR_PERF_CNT_EN
  logic [95:0] perf_grant_cnt;
  logic [31:0] perf_stall_cyc;
`endif

  dram_pair_scheduler_if #(.N_REQ(3), .ID_W(2), .ADDR_W(58)) bus ();

  dram_pair_scheduler #(
    .N_REQ   (3),
    .ID_W    (2),
    .MAX_OUT (8),
    .ADDR_W  (58)
  ) dut (
    .CLK_400M       (clk),
    .spl_reset      (rst),
    .clear          (clear),
    .bus            (bus),
    .outstanding    (outstanding),
    .err_unexpected (err)
`ifdef DRAM_PAIR_PERF_CNT_EN
    ,
    .perf_grant_cnt (perf_grant_cnt),
    .perf_stall_cyc (perf_stall_cyc)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [511:0] actual,
                             input logic [511:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    k_tab[0] = 58'h040; k_tab[1] = 58'h100; k_tab[2] = 58'h180;
    l_tab[0] = 58'h0C0; l_tab[1] = 58'h2A0; l_tab[2] = 58'h3C0;
    beat_a   = {16{32'hAAAA_0001}};
    beat_b   = {16{32'hBBBB_0002}};
    rst   = 1'b1;
    clear = 1'b0;
    bus.req_valid            = 3'b000;
    bus.spl_tx_rd_almostfull = 1'b0;
    bus.io_rx_rd_valid       = 1'b0;
    bus.io_rx_data           = 512'd0;
    for (int i = 0; i < 3; i++) begin
      bus.req_addr_k[i*58 +: 58] = k_tab[i];
      bus.req_addr_l[i*58 +: 58] = l_tab[i];
    end
    step();
    step();
    check_value("rst_tx_valid", bus.cor_tx_rd_valid, 1'b0);
    check_value("rst_outstanding", outstanding, 4'd0);
    check_value("rst_err", err, 1'b0);
    check_value("rst_rsp_valid", bus.rsp_valid, 1'b0);
    rst = 1'b0;
    step();
    check_value("idle_ready", bus.req_ready, 3'b000);

    // Single pair from requester 1
    bus.req_valid = 3'b010;
    #1;
    check_value("t1_ready", bus.req_ready, 3'b010);
    step();
    bus.req_valid = 3'b000;
    check_value("t1_tx_valid_k", bus.cor_tx_rd_valid, 1'b1);
    check_value("t1_tx_addr_k", bus.cor_tx_rd_addr, 58'h100);
    check_value("t1_out_1", outstanding, 4'd1);
    step();
    check_value("t1_tx_valid_l", bus.cor_tx_rd_valid, 1'b1);
    check_value("t1_tx_addr_l", bus.cor_tx_rd_addr, 58'h2A0);
    step();
    check_value("t1_tx_idle", bus.cor_tx_rd_valid, 1'b0);
    bus.io_rx_rd_valid = 1'b1;
    bus.io_rx_data     = beat_a;
    step();
    bus.io_rx_data = beat_b;
    check_value("t1_rsp_early", bus.rsp_valid, 1'b0);
    check_value("t1_out_hold", outstanding, 4'd1);
    step();
    bus.io_rx_rd_valid = 1'b0;
    check_value("t1_rsp_valid", bus.rsp_valid, 1'b1);
    check_value("t1_rsp_id", bus.rsp_id, 2'd1);
    check_value("t1_rsp_k", bus.rsp_data_k, beat_a);
    check_value("t1_rsp_l", bus.rsp_data_l, beat_b);
    check_value("t1_out_0", outstanding, 4'd0);
    step();
    check_value("t1_rsp_pulse", bus.rsp_valid, 1'b0);

    // Clear resets pointer; then round-robin over three held requesters
    do_clear();
    check_value("clr_outstanding", outstanding, 4'd0);
    bus.req_valid = 3'b111;
    for (int g = 0; g < 6; g++) begin
      #1;
      check_value("t2_grant", bus.req_ready, 3'b001 << (g % 3));
      step();
      check_value("t2_tx_k", bus.cor_tx_rd_addr, k_tab[g % 3]);
      step();
      check_value("t2_tx_l", bus.cor_tx_rd_addr, l_tab[g % 3]);
    end
    bus.req_valid = 3'b000;
    check_value("t2_outstanding", outstanding, 4'd6);

    // Fill to the credit limit, then one returned pair frees one grant
    bus.req_valid = 3'b001;
    for (int g = 0; g < 2; g++) begin
      #1;
      check_value("t3_fill_grant", bus.req_ready, 3'b001);
      step();
      step();
    end
    check_value("t3_out_max", outstanding, 4'd8);
    for (int c = 0; c < 3; c++) begin
      #1;
      check_value("t3_blocked", bus.req_ready, 3'b000);
      step();
    end
    check_value("t3_tx_idle", bus.cor_tx_rd_valid, 1'b0);
    bus.io_rx_rd_valid = 1'b1;
    bus.io_rx_data     = beat_a;
    step();
    bus.io_rx_data = beat_b;
    step();
    bus.io_rx_rd_valid = 1'b0;
    check_value("t3_rsp_valid", bus.rsp_valid, 1'b1);
    check_value("t3_rsp_id", bus.rsp_id, 2'd0);
    check_value("t3_out_7", outstanding, 4'd7);
    #1;
    check_value("t3_release", bus.req_ready, 3'b001);
    step();
    check_value("t3_out_8", outstanding, 4'd8);
    check_value("t3_tx_k", bus.cor_tx_rd_addr, k_tab[0]);
    step();
    check_value("t3_tx_l", bus.cor_tx_rd_addr, l_tab[0]);
    #1;
    check_value("t3_blocked_again", bus.req_ready, 3'b000);
    bus.req_valid = 3'b000;

    // almostfull raised during ISSUE_L: l still issued, ARB holds
    do_clear();
    bus.req_valid = 3'b100;
    #1;
    check_value("t4_grant", bus.req_ready, 3'b100);
    step();
    bus.req_valid            = 3'b010;
    bus.spl_tx_rd_almostfull = 1'b1;
    check_value("t4_tx_k", bus.cor_tx_rd_addr, k_tab[2]);
    step();
    check_value("t4_tx_l_valid", bus.cor_tx_rd_valid, 1'b1);
    check_value("t4_tx_l", bus.cor_tx_rd_addr, l_tab[2]);
    for (int c = 0; c < 4; c++) begin
      #1;
      check_value("t4_af_hold", bus.req_ready, 3'b000);
      step();
      check_value("t4_af_tx", bus.cor_tx_rd_valid, 1'b0);
    end
    bus.spl_tx_rd_almostfull = 1'b0;
    #1;
    check_value("t4_af_release", bus.req_ready, 3'b010);
    step();
    bus.req_valid = 3'b000;
    check_value("t4_tx_k_next", bus.cor_tx_rd_addr, k_tab[1]);
`ifdef DRAM_PAIR_PERF_CNT_EN
    check_value("perf_stall", perf_stall_cyc, 32'd4);
    do_clear();
    bus.req_valid = 3'b100;
    for (int g = 0; g < 5; g++) begin
      #1;
      check_value("perf_grant_r2", bus.req_ready, 3'b100);
      step();
      step();
    end
    bus.req_valid = 3'b000;
    check_value("perf_grant_cnt2", perf_grant_cnt[64 +: 32], 32'd5);
    check_value("perf_grant_cnt0", perf_grant_cnt[0 +: 32], 32'd0);
    check_value("perf_stall_none", perf_stall_cyc, 32'd0);
`endif

    // Beats with nothing in flight flag an error and never underflow credits
    do_clear();
    bus.io_rx_rd_valid = 1'b1;
    bus.io_rx_data     = beat_a;
    step();
    bus.io_rx_rd_valid = 1'b0;
    check_value("t5_err_set", err, 1'b1);
    check_value("t5_out_zero", outstanding, 4'd0);
    bus.io_rx_rd_valid = 1'b1;
    bus.io_rx_data     = beat_b;
    step();
    bus.io_rx_rd_valid = 1'b0;
    check_value("t5_no_underflow", outstanding, 4'd0);
    check_value("t5_err_sticky", err, 1'b1);
    step();
    do_clear();
    check_value("t5_clr_err", err, 1'b0);
    check_value("t5_clr_out", outstanding, 4'd0);
    check_value("t5_clr_tx", bus.cor_tx_rd_valid, 1'b0);
    check_value("t5_clr_rsp", bus.rsp_valid, 1'b0);

    // After clear, rx phase restarts at k
    bus.req_valid = 3'b001;
    step();
    bus.req_valid = 3'b000;
    step();
    bus.io_rx_rd_valid = 1'b1;
    bus.io_rx_data     = beat_b;
    step();
    bus.io_rx_data = beat_a;
    step();
    bus.io_rx_rd_valid = 1'b0;
    check_value("t5_post_rsp", bus.rsp_valid, 1'b1);
    check_value("t5_post_k", bus.rsp_data_k, beat_b);
    check_value("t5_post_l", bus.rsp_data_l, beat_a);
    check_value("t5_post_err", err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
